// File: rtl/otter_decode_stage.sv
// -----------------------------------------------------------------------------
// otter_decode_stage
//
// Registered ID stage decoder for the pipelined OTTER RV32I core. One
// instruction is decoded per cycle from the IF/ID register into the ID/EX
// control bundle. Both sides use valid/ready handshakes.
//
// The decoder also provides:
//   - optional M-extension decode (ENABLE_M),
//   - an issue lock while a multi-cycle MUL/DIV occupies EX (MD_LAT > 1),
//   - load-use bubble insertion,
//   - flush, rd==x0 write suppression and illegal-opcode flagging.
//
// Parameters
//   ENABLE_M   1: OP with funct7=0000001 decodes as MUL/DIV, 0: ILLEGAL
//   MD_LAT     cycles the MUL/DIV unit occupies EX (>=1), 1 = no lock
//   CNT_W      busy counter width, derived from MD_LAT
//
// Ports
//   CLK, RST_N             clock, synchronous active-low reset
//   FLUSH                  kill the ID/EX slot and abort the MUL/DIV lock
//   IN_VALID/IN_INSTR      instruction from IF/ID
//   IN_READY               instruction accepted this cycle
//   OUT_VALID/OUT_READY    ID/EX bundle handshake
//   ALU_SRCA..RS2          decoded control bundle (registered)
// -----------------------------------------------------------------------------
module otter_decode_stage #(
    parameter int ENABLE_M = 1,
    parameter int MD_LAT   = 4,
    localparam int CNT_W   = $clog2(MD_LAT + 1)
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    input  logic [31:0] IN_INSTR,
    output logic        IN_READY,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        ALU_SRCA,
    output logic [1:0]  ALU_SRCB,
    output logic [4:0]  ALU_FUN,
    output logic [1:0]  RF_WR_SEL,
    output logic        REG_WRITE,
    output logic        MEM_WRITE,
    output logic        MEM_READ,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_UNS,
    output logic        IS_BR,
    output logic        IS_JAL,
    output logic        IS_JALR,
    output logic        IS_MRET,
    output logic        ILLEGAL,
    output logic [4:0]  RD,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2
);

    // ---------------------------------------------------------------------
    // Opcode map
    // ---------------------------------------------------------------------
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_COPY   = 5'b01001;

    // A lock is only needed when the MUL/DIV unit is not fully pipelined.
    localparam bit MD_LOCK = (MD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Instruction fields
    // ---------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = IN_INSTR[6:0];
    assign rd_f   = IN_INSTR[11:7];
    assign f3     = IN_INSTR[14:12];
    assign rs1_f  = IN_INSTR[19:15];
    assign rs2_f  = IN_INSTR[24:20];
    assign f7     = IN_INSTR[31:25];

    logic op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load;
    logic op_store, op_op_imm, op_op, op_fence, op_system;
    logic m_enc, is_md, known_opc, illegal_dec;

    assign op_lui    = (opcode == OPC_LUI);
    assign op_auipc  = (opcode == OPC_AUIPC);
    assign op_jal    = (opcode == OPC_JAL);
    assign op_jalr   = (opcode == OPC_JALR);
    assign op_branch = (opcode == OPC_BRANCH);
    assign op_load   = (opcode == OPC_LOAD);
    assign op_store  = (opcode == OPC_STORE);
    assign op_op_imm = (opcode == OPC_OP_IMM);
    assign op_op     = (opcode == OPC_OP);
    assign op_fence  = (opcode == OPC_FENCE);
    assign op_system = (opcode == OPC_SYSTEM);

    assign known_opc = op_lui | op_auipc | op_jal | op_jalr | op_branch |
                       op_load | op_store | op_op_imm | op_op | op_fence |
                       op_system;

    // funct7=0000001 on OP is the M-extension group.
    assign m_enc       = op_op && (f7 == 7'b0000001);
    assign is_md       = m_enc && (ENABLE_M != 0);
    assign illegal_dec = !known_opc || (m_enc && (ENABLE_M == 0));

    // Register usage of the incoming instruction, for hazard detection.
    logic uses_rs1, uses_rs2;
    assign uses_rs1 = !(op_lui | op_auipc | op_jal);
    assign uses_rs2 = op_op | op_store | op_branch;

    // ---------------------------------------------------------------------
    // Combinational decode -> next bundle
    // ---------------------------------------------------------------------
    logic       alu_srca_d;
    logic [1:0] alu_srcb_d;
    logic [4:0] alu_fun_d;
    logic [1:0] rf_wr_sel_d;
    logic       reg_write_d;
    logic       mem_write_d;
    logic       mem_read_d;
    logic [1:0] mem_size_d;
    logic       mem_uns_d;
    logic       is_br_d, is_jal_d, is_jalr_d, is_mret_d;

    always_comb begin
        alu_srca_d  = op_lui | op_auipc;

        alu_srcb_d  = 2'd0;
        if (op_load || op_jal || op_jalr || op_op_imm) begin
            alu_srcb_d = 2'd1;
        end else if (op_store) begin
            alu_srcb_d = 2'd2;
        end else if (op_auipc) begin
            alu_srcb_d = 2'd3;
        end

        alu_fun_d = 5'd0;
        if (op_op) begin
            alu_fun_d = is_md ? {2'b10, f3} : {1'b0, f7[5], f3};
        end else if (op_op_imm) begin
            // Only the shift-right group carries an arithmetic/logical bit.
            alu_fun_d = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
        end else if (op_lui || op_system) begin
            alu_fun_d = ALU_COPY;
        end

        rf_wr_sel_d = 2'd3;
        if (op_jal || op_jalr) begin
            rf_wr_sel_d = 2'd0;
        end else if (op_system) begin
            rf_wr_sel_d = 2'd1;
        end else if (op_load) begin
            rf_wr_sel_d = 2'd2;
        end

        // Writes to x0 are suppressed here so EX/WB never see them.
        reg_write_d = !(op_branch || op_store || illegal_dec) && (rd_f != 5'd0);
        mem_write_d = op_store && !illegal_dec;
        mem_read_d  = op_load && !illegal_dec;
        mem_size_d  = (op_load || op_store) ? f3[1:0] : 2'd0;
        mem_uns_d   = op_load ? f3[2] : 1'b0;

        is_br_d     = op_branch;
        is_jal_d    = op_jal;
        is_jalr_d   = op_jalr;
        is_mret_d   = op_system && (f3 == 3'b000);
    end

    // ---------------------------------------------------------------------
    // Bundle registers
    // ---------------------------------------------------------------------
    logic       out_valid_q;
    logic       alu_srca_q;
    logic [1:0] alu_srcb_q;
    logic [4:0] alu_fun_q;
    logic [1:0] rf_wr_sel_q;
    logic       reg_write_q;
    logic       mem_write_q;
    logic       mem_read_q;
    logic [1:0] mem_size_q;
    logic       mem_uns_q;
    logic       is_br_q, is_jal_q, is_jalr_q, is_mret_q;
    logic       illegal_q;
    logic [4:0] rd_q, rs1_q, rs2_q;

    // ---------------------------------------------------------------------
    // Hazard detection and MUL/DIV lock FSM
    // ---------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            hazard;
    logic            md_start;
    logic            busy;
    logic            in_ready_d;
    logic            accept;

    // Load-use: the loaded value is not available to an instruction
    // decoded directly behind the load, so hold it back one cycle.
    assign hazard = out_valid_q && mem_read_q && (rd_q != 5'd0) && IN_VALID &&
                    ((uses_rs1 && (rs1_f == rd_q)) || (uses_rs2 && (rs2_f == rd_q)));

    // The lock starts on the transfer of an M-op; nothing is accepted in
    // that cycle so the next instruction cannot slip in behind it.
    assign md_start = MD_LOCK && out_valid_q && OUT_READY && alu_fun_q[4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // Counter at 0 releases the lock and allows an accept in
                // the same cycle.
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    busy  = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        in_ready_d = RST_N && !FLUSH && !hazard && !busy && !md_start &&
                     (!out_valid_q || OUT_READY);
    end

    assign accept = IN_VALID && in_ready_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (FLUSH) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            alu_srca_q  <= 1'b0;
            alu_srcb_q  <= 2'd0;
            alu_fun_q   <= 5'd0;
            rf_wr_sel_q <= 2'd0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_uns_q   <= 1'b0;
            is_br_q     <= 1'b0;
            is_jal_q    <= 1'b0;
            is_jalr_q   <= 1'b0;
            is_mret_q   <= 1'b0;
            illegal_q   <= 1'b0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
        end else if (FLUSH) begin
            // A concurrent OUT_READY transfer still completes: EX has it.
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_srca_q  <= alu_srca_d;
            alu_srcb_q  <= alu_srcb_d;
            alu_fun_q   <= alu_fun_d;
            rf_wr_sel_q <= rf_wr_sel_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_size_q  <= mem_size_d;
            mem_uns_q   <= mem_uns_d;
            is_br_q     <= is_br_d;
            is_jal_q    <= is_jal_d;
            is_jalr_q   <= is_jalr_d;
            is_mret_q   <= is_mret_d;
            illegal_q   <= illegal_dec;
            rd_q        <= rd_f;
            rs1_q       <= rs1_f;
            rs2_q       <= rs2_f;
        end else if (OUT_READY) begin
            // Transfer without a replacement: a bubble (load-use, lock).
            out_valid_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign IN_READY  = in_ready_d;
    assign OUT_VALID = out_valid_q;
    assign ALU_SRCA  = alu_srca_q;
    assign ALU_SRCB  = alu_srcb_q;
    assign ALU_FUN   = alu_fun_q;
    assign RF_WR_SEL = rf_wr_sel_q;
    assign REG_WRITE = reg_write_q;
    assign MEM_WRITE = mem_write_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_SIZE  = mem_size_q;
    assign MEM_UNS   = mem_uns_q;
    assign IS_BR     = is_br_q;
    assign IS_JAL    = is_jal_q;
    assign IS_JALR   = is_jalr_q;
    assign IS_MRET   = is_mret_q;
    assign ILLEGAL   = illegal_q;
    assign RD        = rd_q;
    assign RS1       = rs1_q;
    assign RS2       = rs2_q;

endmodule
